pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter and fetch sequencer for the single-cycle core: it consumes the 2-bit `pc_source` select produced by the branch decision logic, computes the next PC, and drives a request/ready handshake toward instruction memory. It holds the fetched instruction stable for the datapath until the core signals `retire`, then commits the selected next PC and fetches again.

## Interface
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded on reset.
- `TRAP_VECTOR`, 32'h0000_0100, redirect target on a misaligned target. Used only with `PC_MISALIGN_TRAP_EN`.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_source`  in  2  next-PC select, encoded per `defines.v`: `PC_NEXT_INST`, `PC_BRANCH_OFFSET`, `PC_ALU_RESULT`. The fourth code is reserved.
- `branch_offset`  in  32  sign-extended branch immediate.
- `alu_result`  in  32  jump target from the ALU.
- `retire`  in  1  current instruction has executed; commit next PC.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_ready`  in  1  `imem_rdata` is valid this cycle; completes the request.
- `imem_rdata`  in  32  fetched instruction word.
- `inst_valid`  out  1  `inst` holds the instruction at `pc`.
- `inst`  out  32  registered instruction.
- `pc`  out  32  current PC register.
- `misalign_trap`  out  1  one-cycle trap pulse. Present only with the macro; without it, tied to 0.
- `trap_addr`  out  32  offending target. Present only with the macro; without it, tied to 0.

## Operation
- **States:** FETCH, EXEC. With the macro, a third state, TRAP.
- **Reset:**
  - State = FETCH.
  - `pc` = RESET_VECTOR.
  - `inst` = 0, `inst_valid` = 0, `imem_req` = 0, `misalign_trap` = 0, `trap_addr` = 0.
  - `imem_req` rises on the first cycle after `rst` deasserts.
- **FETCH:**
  - `imem_req` = 1 and `imem_addr` = `pc`; both hold stable until `imem_ready`.
  - On `imem_ready`: `inst` <= `imem_rdata`, `inst_valid` <= 1, `imem_req` <= 0, go to EXEC.
- **EXEC:**
  - `inst_valid` = 1 and `inst` holds stable.
  - `pc_source`, `branch_offset` and `alu_result` are sampled only in the cycle `retire` = 1.
  - On `retire`: `pc` <= next_pc, `inst_valid` <= 0, go to FETCH.
  - `retire` is ignored outside EXEC.
- **next_pc:**
  - `PC_NEXT_INST` → `pc` + 4.
  - `PC_BRANCH_OFFSET` → `pc` + `branch_offset`.
  - `PC_ALU_RESULT` → {`alu_result`[31:1], 1'b0}.
  - Reserved code → `pc` + 4.
  - All adds are 32-bit, modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000. Carry is discarded.
- **Misaligned target** (next_pc[1:0] ≠ 0): behaviour depends on the macro; see Configuration.
- **`imem_ready` outside FETCH:** ignored.

## Timing
- Best-case fetch: `imem_req` high in cycle N, `imem_ready` in cycle N → `inst_valid` = 1 in cycle N+1.
- Retire → new request: `retire` in cycle M → `pc` updated and `imem_req` = 1 in cycle M+1.
- Minimum instruction period is 2 cycles: one FETCH cycle, one EXEC cycle.
- `imem_ready` held low for k cycles stretches FETCH by k cycles; `imem_addr` holds constant throughout.
- **`rst` with `imem_ready` or `retire` in the same cycle:** reset wins, and the response or retire is dropped.
- **Reset mid-FETCH:** the outstanding request is abandoned. `imem_req` = 0 in the cycle after the reset edge.

## Configuration
- **`PC_MISALIGN_TRAP_EN` defined:**
  - A retire with misaligned next_pc sets `pc` <= TRAP_VECTOR, `trap_addr` <= next_pc, `misalign_trap` <= 1.
  - The block then enters TRAP for exactly one cycle, and `misalign_trap` is high only during that cycle.
  - TRAP → FETCH, and fetch proceeds from TRAP_VECTOR.
  - `trap_addr` holds its value until the next trap or reset.
- **`PC_MISALIGN_TRAP_EN` undefined:**
  - There is no TRAP state; `misalign_trap` and `trap_addr` are constant 0.
  - A misaligned next_pc is committed as computed and fetched from that address.

## Test plan
- **Reset:** hold `rst` 2 cycles, RESET_VECTOR = 0 → all outputs 0. `imem_req` = 1 with `imem_addr` = 0 in the first cycle after release.
- **Sequential fetch:** `imem_ready` tied 1, `pc_source` = `PC_NEXT_INST`, `retire` asserted each EXEC → `pc` sequence 0, 4, 8, 12. `inst` matches memory each time, with a 2-cycle period.
- **Branch and jump:**
  - At `pc` = 0x40, `PC_BRANCH_OFFSET` with offset 0xFFFF_FFF0 → `pc` = 0x30.
  - `PC_ALU_RESULT` with `alu_result` = 0x101 → `pc` = 0x100.
  - Reserved code 2'b11 → `pc` + 4.
- **Wait states and wrap:**
  - Hold `imem_ready` low 3 cycles → `imem_req` and `imem_addr` stay stable; `inst_valid` stays 0 until 1 cycle after ready.
  - `pc` = 0xFFFF_FFFC with next-inst → `pc` = 0.
- **Reset mid-operation:** assert `rst` in the same cycle as `imem_ready` → `inst_valid` stays 0, `pc` = RESET_VECTOR, and the fetch restarts.
- **Misaligned branch:** `branch_offset` = 2 at `pc` = 0x10.
  - With macro: `pc` = 0x100, `trap_addr` = 0x12, `misalign_trap` high exactly 1 cycle.
  - Without macro: `pc` = 0x12, `misalign_trap` = 0.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Next-PC selection and fetch handshake. The fetched word is held
//            until retire. Define PC_MISALIGN_TRAP_EN to redirect misaligned
//            targets to TRAP_VECTOR.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pc_source,
    input  logic [31:0] branch_offset,
    input  logic [31:0] alu_result,
    input  logic        retire,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        misalign_trap,
    output logic [31:0] trap_addr
);

    localparam logic [1:0] c_PC_NEXT_INST     = 2'b00;
    localparam logic [1:0] c_PC_BRANCH_OFFSET = 2'b01;
    localparam logic [1:0] c_PC_ALU_RESULT    = 2'b10;

    localparam logic [1:0] c_FETCH = 2'd0;
    localparam logic [1:0] c_EXEC  = 2'd1;
`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [1:0] c_TRAP  = 2'd2;
`endif

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_inst_valid;
    logic        r_req;
    logic [31:0] w_next_pc;

    // Reserved select falls through to sequential execution.
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        case (pc_source)
            c_PC_NEXT_INST:     w_next_pc = r_pc + 32'd4;
            c_PC_BRANCH_OFFSET: w_next_pc = r_pc + branch_offset;
            c_PC_ALU_RESULT:    w_next_pc = {alu_result[31:1], 1'b0};
            default:            w_next_pc = r_pc + 32'd4;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic        r_trap;
    logic [31:0] r_trap_addr;
    logic        w_misaligned;

    assign w_misaligned  = |w_next_pc[1:0];
    assign misalign_trap = r_trap;
    assign trap_addr     = r_trap_addr;
`else
    logic [31:0] w_unused_trap_vector;

    assign w_unused_trap_vector = TRAP_VECTOR;
    assign misalign_trap        = 1'b0;
    assign trap_addr            = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_FETCH;
            r_pc         <= RESET_VECTOR;
            r_inst       <= 32'd0;
            r_inst_valid <= 1'b0;
            r_req        <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            r_trap       <= 1'b0;
            r_trap_addr  <= 32'd0;
`endif
        end else begin
            case (r_state)
                c_FETCH: begin
                    // Only the first cycle out of reset sees FETCH without a request.
                    if (!r_req) begin
                        r_req <= 1'b1;
                    end else if (imem_ready) begin
                        r_inst       <= imem_rdata;
                        r_inst_valid <= 1'b1;
                        r_req        <= 1'b0;
                        r_state      <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    if (retire) begin
                        r_inst_valid <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
                        if (w_misaligned) begin
                            r_pc        <= TRAP_VECTOR;
                            r_trap_addr <= w_next_pc;
                            r_trap      <= 1'b1;
                            r_state     <= c_TRAP;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_req   <= 1'b1;
                            r_state <= c_FETCH;
                        end
`else
                        r_pc    <= w_next_pc;
                        r_req   <= 1'b1;
                        r_state <= c_FETCH;
`endif
                    end
                end
`ifdef PC_MISALIGN_TRAP_EN
                c_TRAP: begin
                    r_trap  <= 1'b0;
                    r_req   <= 1'b1;
                    r_state <= c_FETCH;
                end
`endif
                default: begin
                    r_state      <= c_FETCH;
                    r_req        <= 1'b0;
                    r_inst_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign inst       = r_inst;
    assign inst_valid = r_inst_valid;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Randomised scoreboard bench for pc_sequencer with a behavioural
//            next-PC model and directed branch/jump/wrap/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] c_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] c_TRAP_VECTOR  = 32'h0000_0100;
    localparam logic [1:0]  c_NEXT   = 2'b00;
    localparam logic [1:0]  c_BRANCH = 2'b01;
    localparam logic [1:0]  c_ALU    = 2'b10;
    localparam logic [1:0]  c_RSVD   = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pc_source;
    logic [31:0] branch_offset;
    logic [31:0] alu_result;
    logic        retire;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        misalign_trap;
    logic [31:0] trap_addr;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_VECTOR (c_RESET_VECTOR),
        .TRAP_VECTOR  (c_TRAP_VECTOR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_source     (pc_source),
        .branch_offset (branch_offset),
        .alu_result    (alu_result),
        .retire        (retire),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .pc            (pc),
        .misalign_trap (misalign_trap),
        .trap_addr     (trap_addr)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] trap_q[$];
    logic [65:0] dir_q[$];
    logic [31:0] pc_log[$];
    int          period_q[$];
    logic [31:0] m_pc;
    int          ready_pct  = 70;
    int          retire_pct = 50;
    int          hold_ready = 0;
    bit          random_en  = 1'b0;

    logic [31:0] seq_a [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
`ifdef PC_MISALIGN_TRAP_EN
    logic [31:0] seq_b [9] = '{32'h40, 32'h30, 32'h100, 32'h104, 32'hFFFF_FFFC,
                               32'h0, 32'h10, 32'h100, 32'h104};
`else
    logic [31:0] seq_b [9] = '{32'h40, 32'h30, 32'h100, 32'h104, 32'hFFFF_FFFC,
                               32'h0, 32'h10, 32'h12, 32'h16};
`endif

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [1:0] s,
                                             input logic [31:0] off, input logic [31:0] alu);
        if (s == c_BRANCH) return p + off;
        if (s == c_ALU)    return alu & 32'hFFFF_FFFE;
        return p + 32'd4;
    endfunction

    function automatic logic [65:0] mk(input logic [1:0] s, input logic [31:0] off,
                                       input logic [31:0] alu);
        return {s, off, alu};
    endfunction

    function automatic logic [65:0] rand_cmd();
        logic [31:0] off;
        logic [31:0] alu;
        logic [1:0]  s;
        s   = 2'($urandom_range(0, 3));
        off = (32'($urandom_range(0, 255)) - 32'd128) << 2;
        alu = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0) begin
            off = off + 32'($urandom_range(1, 3));
            alu = alu | 32'h2;
        end
        return {s, off, alu};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    task automatic issue(input logic [65:0] cmd);
        logic [31:0] nxt;
        retire        = 1'b1;
        pc_source     = cmd[65:64];
        branch_offset = cmd[63:32];
        alu_result    = cmd[31:0];
        nxt = ref_next(m_pc, cmd[65:64], cmd[63:32], cmd[31:0]);
`ifdef PC_MISALIGN_TRAP_EN
        if (nxt[1:0] != 2'b00) begin
            trap_q.push_back(nxt);
            nxt = c_TRAP_VECTOR;
        end
`endif
        m_pc = nxt;
        exp_q.push_back(nxt);
    endtask

    // Memory responder plus core-side retire driver for one cycle.
    task automatic drive();
        if (imem_req) begin
            if (hold_ready > 0) begin
                imem_ready = 1'b0;
                hold_ready--;
            end else begin
                imem_ready = ($urandom_range(0, 99) < ready_pct);
            end
            imem_rdata = imem_ready ? mem_word(imem_addr) : $urandom;
        end else begin
            imem_ready = inst_valid && ($urandom_range(0, 3) == 0);
            imem_rdata = $urandom;
        end
        retire        = 1'b0;
        pc_source     = 2'($urandom_range(0, 3));
        branch_offset = $urandom;
        alu_result    = $urandom;
        if (inst_valid) begin
            if (dir_q.size() > 0) issue(dir_q.pop_front());
            else if (random_en && ($urandom_range(0, 99) < retire_pct)) issue(rand_cmd());
        end else begin
            retire = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!(dir_q.size() == 0 && exp_q.size() == 0 && inst_valid) && k < 3000);
        if (k >= 3000) fail_now({name, "_drain_timeout"});
    endtask

    // Monitor: pops the scoreboard whenever a new instruction is presented.
    int          cyc = 0;
    int          rdy_cyc = -10;
    int          last_rise = -1;
    logic        prev_valid = 1'b0;
    logic        prev_ret = 1'b0;
    logic        prev_trap = 1'b0;
    logic [31:0] e_pc;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_valid = 1'b0;
            prev_ret   = 1'b0;
            prev_trap  = 1'b0;
            last_rise  = -1;
        end else begin
            if (imem_req) begin
                check("addr_eq_pc", imem_addr, pc);
                if (exp_q.size() > 0) check("fetch_addr", imem_addr, exp_q[0]);
                else fail_now("req_unexpected");
                if (imem_ready) rdy_cyc = cyc;
            end
            if (inst_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("valid_unexpected");
                end else begin
                    e_pc = exp_q.pop_front();
                    check("exec_pc", pc, e_pc);
                    check("exec_inst", inst, mem_word(e_pc));
                end
                check("fetch_latency", 32'(cyc), 32'(rdy_cyc + 1));
                pc_log.push_back(pc);
                if (last_rise >= 0) period_q.push_back(cyc - last_rise);
                last_rise = cyc;
            end
            if (prev_ret) check("retire_to_next", 32'(imem_req | misalign_trap), 32'd1);
`ifdef PC_MISALIGN_TRAP_EN
            if (misalign_trap) begin
                check("trap_one_cycle", 32'(prev_trap), 32'd0);
                if (trap_q.size() > 0) check("trap_addr", trap_addr, trap_q.pop_front());
                else fail_now("trap_unexpected");
                check("trap_pc", pc, c_TRAP_VECTOR);
            end
`else
            check("trap_tied_zero", trap_addr | 32'(misalign_trap), 32'd0);
`endif
            prev_valid = inst_valid;
            prev_ret   = retire && inst_valid;
            prev_trap  = misalign_trap;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; retire = 1'b0; pc_source = 2'b00; branch_offset = 32'd0;
        alu_result = 32'd0; imem_ready = 1'b0; imem_rdata = 32'd0;

        // Reset held for two edges.
        @(posedge clk); #1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_pc", pc, c_RESET_VECTOR);
        check("rst_trap", 32'(misalign_trap), 32'd0);
        check("rst_trap_addr", trap_addr, 32'd0);

        for (int i = 0; i < 4; i++) dir_q.push_back(mk(c_NEXT, 32'd0, 32'd0));
        ready_pct  = 100;
        rst        = 1'b0;
        imem_ready = 1'b0;
        m_pc       = c_RESET_VECTOR;
        exp_q.push_back(c_RESET_VECTOR);
        @(posedge clk); #1;
        check("release_req", 32'(imem_req), 32'd1);
        check("release_addr", imem_addr, c_RESET_VECTOR);
        drive();
        drain("seq");
        if (period_q.size() < 4 || pc_log.size() < 4) begin
            fail_now("seq_count");
        end else begin
            for (int i = 0; i < 4; i++) begin
                check("seq_period", 32'(period_q[i]), 32'd2);
                check("seq_pc", pc_log[i], seq_a[i]);
            end
        end

        // Branch, jump, reserved, wrap and misaligned target, with wait states.
        pc_log.delete();
        ready_pct  = 50;
        hold_ready = 3;
        dir_q.push_back(mk(c_ALU,    32'd0,         32'h40));
        dir_q.push_back(mk(c_BRANCH, 32'hFFFF_FFF0, 32'd0));
        dir_q.push_back(mk(c_ALU,    32'd0,         32'h101));
        dir_q.push_back(mk(c_RSVD,   32'h1234_5670, 32'h8));
        dir_q.push_back(mk(c_ALU,    32'd0,         32'hFFFF_FFFC));
        dir_q.push_back(mk(c_NEXT,   32'd0,         32'd0));
        dir_q.push_back(mk(c_ALU,    32'd0,         32'h10));
        dir_q.push_back(mk(c_BRANCH, 32'd2,         32'd0));
        dir_q.push_back(mk(c_NEXT,   32'd0,         32'd0));
        drain("directed");
        if (pc_log.size() < 9) begin
            fail_now("directed_count");
        end else begin
            for (int i = 0; i < 9; i++) check("directed_pc", pc_log[i], seq_b[i]);
        end
`ifdef PC_MISALIGN_TRAP_EN
        check("trap_addr_held", trap_addr, 32'h12);
`else
        check("no_trap_addr", trap_addr, 32'd0);
`endif

        // Random traffic.
        random_en  = 1'b1;
        ready_pct  = 60;
        retire_pct = 40;
        repeat (600) cycle();
        random_en = 1'b0;
        drain("random");

        // Reset in the same cycle as imem_ready.
        random_en = 1'b1;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!imem_req && k < 200);
        if (!imem_req) begin
            fail_now("midreset_no_req");
        end else begin
            random_en  = 1'b0;
            rst        = 1'b1;
            retire     = 1'b0;
            imem_ready = 1'b1;
            imem_rdata = mem_word(imem_addr);
            exp_q.delete();
            trap_q.delete();
            @(posedge clk); #1;
            check("midrst_valid", 32'(inst_valid), 32'd0);
            check("midrst_pc", pc, c_RESET_VECTOR);
            check("midrst_req", 32'(imem_req), 32'd0);
            rst        = 1'b0;
            imem_ready = 1'b0;
            m_pc       = c_RESET_VECTOR;
            exp_q.push_back(c_RESET_VECTOR);
            @(posedge clk); #1;
            check("midrst_restart_req", 32'(imem_req), 32'd1);
            check("midrst_restart_addr", imem_addr, c_RESET_VECTOR);
            drive();
        end
        random_en = 1'b1;
        repeat (150) cycle();
        random_en = 1'b0;
        drain("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
